spi_mem_ctrl: RTL
=================

# spi_mem_ctrl

Finite-state controller that sequences the SPI memory datapath (input conditioners, shift register, data memory, MISO tri-state buffer). It decodes the SPI command byte (7-bit address + R/W bit) and owns the memory address register. It issues the shift-register parallel load, the data-memory write strobe and the MISO output enable. It sits between the conditioned `cs`/`sclk` edge pulses and the datapath enables inside `spiMemory`.

## Interface
- `ADDR_WIDTH`, 7: memory address bits; the command byte carries the address in bits [7:1].
- `WORD_WIDTH`, 8: shift-register and memory word width; also the bit count per byte.
- `clk`  input  1: system clock. All logic is clocked on its rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `cs_cond`  input  1: conditioned chip select. 1 means deselected.
- `sclk_pos`  input  1: one-`clk` pulse on each conditioned SCLK rising edge.
- `sclk_neg`  input  1: one-`clk` pulse on each conditioned SCLK falling edge. Not used for counting; reserved for datapath.
- `shift_pout`  input  WORD_WIDTH: shift-register parallel output.
- `mem_addr`  output  ADDR_WIDTH: data-memory address (registered).
- `sr_load`  output  1: one-cycle shift-register parallel load from memory read data.
- `dm_we`  output  1: one-cycle data-memory write enable. Write data is `shift_pout`.
- `miso_oe`  output  1: MISO buffer enable.
- `busy`  output  1: high in any state other than IDLE.

## Operation
- States: IDLE, ADDR, DECODE, RD_LOAD, RD_SHIFT, WR_RECV, WR_COMMIT, DONE.
- Internal bit counter runs 0..WORD_WIDTH. It clears on every state entry except self-loops and increments on `sclk_pos`.
- IDLE:
  - `cs_cond`=0 → ADDR.
- ADDR:
  - Counts `sclk_pos`.
  - At count 8 → DECODE.
- DECODE (1 cycle):
  - `mem_addr` <= `shift_pout[7:1]`.
  - If `shift_pout[0]`=1 → RD_LOAD; otherwise → WR_RECV.
- RD_LOAD (1 cycle):
  - `sr_load`=1.
  - → RD_SHIFT.
- RD_SHIFT:
  - `miso_oe`=1.
  - Counts `sclk_pos`. At count 8 → DONE.
- WR_RECV:
  - Counts `sclk_pos`.
  - At count 8 → WR_COMMIT.
- WR_COMMIT (1 cycle):
  - `dm_we`=1.
  - → DONE.
- DONE:
  - All strobes low.
  - Holds until `cs_cond`=1.
- Any state, `cs_cond`=1:
  - Next state is IDLE; the bit counter clears.
  - `sr_load`, `dm_we` and `miso_oe` are forced 0 in that same cycle, combinationally gated.
  - Consequence: a write not yet committed is discarded, and a write in WR_COMMIT with `cs_cond`=1 is suppressed.
- `mem_addr` keeps its last value across transactions.
- Both `sclk_pos` and `sclk_neg` high in the same cycle is illegal. If it occurs, `sclk_pos` is counted.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_addr` = 0, `sr_load` = 0, `dm_we` = 0, `miso_oe` = 0, `busy` = 0.
- The 8th `sclk_pos` in ADDR is at cycle t. DECODE is at t+1, sampling `shift_pout`, which is valid after the shift at t.
- Read path:
  - `sr_load` is high at t+2.
  - `miso_oe` rises at t+3 and stays high until DONE or deselect.
- Write path: `dm_we` is high exactly 2 cycles after the 8th data `sclk_pos`.
- Requirement on the master: consecutive `sclk_pos` pulses are at least 4 `clk` apart. This guarantees the load completes before the first data falling edge.
- `rst_n` low mid-transaction: immediate return to reset values. No partial write occurs.

## Configuration
- `SPI_BURST_EN` defined:
  - Read: at count 8 in RD_SHIFT, `mem_addr` <= `mem_addr`+1 (mod 2^ADDR_WIDTH) and → RD_LOAD.
  - Write: WR_COMMIT → WR_RECV and `mem_addr` increments in the cycle after the commit.
  - A transaction ends only on `cs_cond`=1.
- `SPI_BURST_EN` undefined: single-word transactions exactly as described in Operation. DONE is reached after one word.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum `spi_state_t`;
  - constants `SPI_RW_BIT` (=0) and `SPI_CMD_READ` (=1'b1).
- One sub-module, `spi_bit_counter`:
  - Width is $clog2(WORD_WIDTH+1).
  - Inputs: `clk`, `rst_n`, `clr`, `inc`. Output: `done` (count == WORD_WIDTH).
- The FSM uses two processes: registered state/address, and combinational next-state/outputs.

## Test plan
- Write: `cs_cond`=0, shift command byte 0x28 (addr 0x14, write), then data 0x5A → `dm_we` pulses once with `mem_addr`=0x14 and `shift_pout`=0x5A; then DONE.
- Read: command 0x29 → DECODE sets `mem_addr`=0x14. `sr_load` is high exactly one cycle, 2 cycles after the 8th `sclk_pos`. `miso_oe` stays high for 8 SCLK periods, then drops in DONE.
- Abort: write command plus 5 data bits, then `cs_cond`=1 → no `dm_we` ever; IDLE next cycle; a following transaction starts cleanly at count 0.
- Reset: `rst_n` low during RD_SHIFT → all outputs 0 and `mem_addr`=0 immediately, without waiting for a clock edge.
- Burst (with `SPI_BURST_EN`): write command to addr 0x7E, then 3 data bytes → `dm_we` at addresses 0x7E, 0x7F, 0x00 (wrap).
- Deselect during commit: `cs_cond` rises in the WR_COMMIT cycle → `dm_we` stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI memory controller:
//                FSM state encoding and command-byte field definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Controller states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_DECODE    = 3'd2,
        ST_RD_LOAD   = 3'd3,
        ST_RD_SHIFT  = 3'd4,
        ST_WR_RECV   = 3'd5,
        ST_WR_COMMIT = 3'd6,
        ST_DONE      = 3'd7
    } spi_state_t;

    // Position of the R/W flag in the command byte; the address sits above it
    localparam int   SPI_RW_BIT   = 0;
    // R/W flag value that selects a read
    localparam logic SPI_CMD_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_bit_counter
//  Description : Counts SCLK rising-edge pulses from 0 up to WORD_WIDTH and
//                saturates there. Clear has priority over increment.
//                o_last flags the final count before a full word.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_counter #(
    parameter int WORD_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_done,
    output logic o_last
);

    localparam int CW = $clog2(WORD_WIDTH + 1);

    logic [CW-1:0] r_cnt;

    // Bit count: clear on request, otherwise count up to a full word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CW'(WORD_WIDTH))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == CW'(WORD_WIDTH));
    assign o_last = (r_cnt == CW'(WORD_WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_ctrl
//  Description : Sequencer for the SPI memory datapath. Decodes the command
//                byte (address + R/W), owns the memory address register and
//                drives the shift-register load, memory write strobe and MISO
//                output enable. Deselect (i_cs_cond=1) aborts from any state.
//                Optional feature macro: SPI_BURST_EN (auto-incrementing
//                multi-word reads/writes until deselect).
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cs_cond,
    input  logic                  i_sclk_pos,
    input  logic                  i_sclk_neg,
    input  logic [WORD_WIDTH-1:0] i_shift_pout,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_sr_load,
    output logic                  o_dm_we,
    output logic                  o_miso_oe,
    output logic                  o_busy
);

    spi_state_t            r_state;
    spi_state_t            w_next;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  w_addr_ld;
    logic                  w_addr_inc;
    logic                  w_inc;
    logic                  w_clr;
    logic                  w_cnt_done;
    logic                  w_cnt_last;

    // A collision of both edge pulses resolves to the rising edge; the
    // falling-edge pulse belongs to the datapath and never advances the count.
    assign w_inc = i_sclk_pos | (i_sclk_pos & i_sclk_neg);

    // Counter restarts on every state change and whenever deselected
    assign w_clr = (w_next != r_state) || i_cs_cond;

    spi_bit_counter #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .o_done (w_cnt_done),
        .o_last (w_cnt_last)
    );

    // State and address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_addr_ld) begin
                r_mem_addr <= i_shift_pout[SPI_RW_BIT+ADDR_WIDTH -: ADDR_WIDTH];
            end else if (w_addr_inc) begin
                r_mem_addr <= r_mem_addr + 1'b1;
            end
        end
    end

    // Next-state and address-update decode; deselect overrides everything.
    // The command byte exits ADDR on the 8th edge itself so the memory read
    // data is loaded well before the first data falling edge; data bytes
    // wait for the settled count.
    always_comb begin
        w_next     = r_state;
        w_addr_ld  = 1'b0;
        w_addr_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_cnt_done || (w_inc && w_cnt_last)) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_addr_ld = 1'b1;
                w_next    = (i_shift_pout[SPI_RW_BIT] == SPI_CMD_READ) ? ST_RD_LOAD : ST_WR_RECV;
            end
            ST_RD_LOAD: begin
                w_next = ST_RD_SHIFT;
            end
            ST_RD_SHIFT: begin
                if (w_cnt_done) begin
`ifdef SPI_BURST_EN
                    w_addr_inc = 1'b1;
                    w_next     = ST_RD_LOAD;
`else
                    w_next     = ST_DONE;
`endif
                end
            end
            ST_WR_RECV: begin
                if (w_cnt_done) begin
                    w_next = ST_WR_COMMIT;
                end
            end
            ST_WR_COMMIT: begin
`ifdef SPI_BURST_EN
                w_addr_inc = 1'b1;
                w_next     = ST_WR_RECV;
`else
                w_next     = ST_DONE;
`endif
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (i_cs_cond) begin
            w_next     = ST_IDLE;
            w_addr_ld  = 1'b0;
            w_addr_inc = 1'b0;
        end
    end

    // Strobes are gated by deselect in the same cycle so an abort never writes
    assign o_sr_load  = (r_state == ST_RD_LOAD)   && !i_cs_cond;
    assign o_dm_we    = (r_state == ST_WR_COMMIT) && !i_cs_cond;
    assign o_miso_oe  = (r_state == ST_RD_SHIFT)  && !i_cs_cond;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_mem_addr = r_mem_addr;

endmodule
`default_nettype wire
